// File: rtl/cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// cache_port_arbiter
//
// Two-requester arbiter in front of a single-ported write-back cache.
// Port 0 is typically instruction fetch, port 1 the load/store unit. One word
// access at a time is placed on the cache's addr/rd_req/wr_req interface. The
// request is held stable until the cache drops its combinational miss signal.
// The winning port then gets a one-cycle done pulse, with read data valid
// during that pulse. Per-port access and miss counters support miss-rate
// measurement.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin on ties, 1 = port 0 always wins a tie
//   CNT_W      : width of each statistics counter (saturating)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   pN_req              port N request, held by the requester until pN_done
//   pN_we               port N operation: 1 = write, 0 = read
//   pN_addr, pN_wdata   port N byte address and write data
//   pN_done             port N one-cycle completion pulse
//   pN_rdata            port N read data, valid while pN_done = 1, held after
//   c_addr, c_wr_data   address / write data to cache (hold outside ISSUE)
//   c_rd_req, c_wr_req  cache read / write request, only asserted in ISSUE
//   c_miss              combinational miss from the cache
//   c_rd_data           registered read data from the cache
//   clear_stats         synchronous clear of all four counters
//   pN_acc_cnt          completed accesses on port N
//   pN_miss_cnt         accesses on port N that missed on their first cycle
// -----------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic             p0_done,
    output logic [31:0]      p0_rdata,

    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic             p1_done,
    output logic [31:0]      p1_rdata,

    output logic [31:0]      c_addr,
    output logic             c_rd_req,
    output logic             c_wr_req,
    output logic [31:0]      c_wr_data,
    input  logic             c_miss,
    input  logic [31:0]      c_rd_data,

    input  logic             clear_stats,
    output logic [CNT_W-1:0] p0_acc_cnt,
    output logic [CNT_W-1:0] p0_miss_cnt,
    output logic [CNT_W-1:0] p1_acc_cnt,
    output logic [CNT_W-1:0] p1_miss_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Port number of the most recently completed access (drives round-robin)
    logic        last_gnt_q;

    // Request latched at grant; port inputs are ignored from then on
    logic        gnt_port_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // first marks the first ISSUE cycle; missed records a miss seen there
    logic        first_q;
    logic        missed_q;

    logic [31:0] p0_rdata_q;
    logic [31:0] p1_rdata_q;

    logic        any_req;
    logic        gnt_sel;
    logic        in_issue;
    logic        in_resp;
    logic        resp_rd;

    // -------------------------------------------------------------------------
    // Saturating increment shared by all counters
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // -------------------------------------------------------------------------
    // Grant selection (only consumed in IDLE)
    // -------------------------------------------------------------------------
    assign any_req = p0_req | p1_req;

    // NOTE: every signal written in an always_comb gets a default on entry so
    // no path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        gnt_sel = 1'b0;
        if (p0_req && p1_req) begin
            // Round-robin favours the port that was not served last
            gnt_sel = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
        end else if (p1_req) begin
            gnt_sel = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The cache completes the access at the edge where miss is low
                if (!c_miss) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge, independent of the
    // order statements appear in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_issue = (state_q == ISSUE);
    assign in_resp  = (state_q == RESP);
    assign resp_rd  = in_resp && !we_q;

    // -------------------------------------------------------------------------
    // Grant bookkeeping and latched request
    // -------------------------------------------------------------------------
    // NOTE: the latched request registers are reset even though they are pure
    // datapath, because c_addr / c_wr_data come straight from them and must read
    // 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            gnt_port_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            first_q    <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_port_q <= gnt_sel;
                        we_q       <= gnt_sel ? p1_we    : p0_we;
                        addr_q     <= gnt_sel ? p1_addr  : p0_addr;
                        wdata_q    <= gnt_sel ? p1_wdata : p0_wdata;
                        first_q    <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Only a miss on the first cycle classifies the access
                    if (c_miss) begin
                        missed_q <= missed_q | first_q;
                    end
                    first_q <= 1'b0;
                    if (!c_miss) begin
                        last_gnt_q <= gnt_port_q;
                    end
                end
                RESP: begin
                    missed_q <= 1'b0;
                end
                default: begin
                    first_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Cache interface. Address and write data come straight from the latched
    // registers, which only change at a grant, so they keep their last value
    // outside ISSUE.
    // -------------------------------------------------------------------------
    assign c_addr    = addr_q;
    assign c_wr_data = wdata_q;
    assign c_rd_req  = in_issue && !we_q;
    assign c_wr_req  = in_issue &&  we_q;

    // -------------------------------------------------------------------------
    // Response path. The cache registers its read data at the completing edge,
    // so it is only visible during RESP. The port's rdata forwards it in that
    // cycle and captures it into the holding register at the end of RESP.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else if (resp_rd) begin
            if (gnt_port_q) begin
                p1_rdata_q <= c_rd_data;
            end else begin
                p0_rdata_q <= c_rd_data;
            end
        end
    end

    assign p0_done  = in_resp && !gnt_port_q;
    assign p1_done  = in_resp &&  gnt_port_q;
    assign p0_rdata = (resp_rd && !gnt_port_q) ? c_rd_data : p0_rdata_q;
    assign p1_rdata = (resp_rd &&  gnt_port_q) ? c_rd_data : p1_rdata_q;

    // -------------------------------------------------------------------------
    // Statistics counters; clear takes priority over a same-cycle increment
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_acc_cnt  <= '0;
            p0_miss_cnt <= '0;
            p1_acc_cnt  <= '0;
            p1_miss_cnt <= '0;
        end else if (clear_stats) begin
            p0_acc_cnt  <= '0;
            p0_miss_cnt <= '0;
            p1_acc_cnt  <= '0;
            p1_miss_cnt <= '0;
        end else if (in_resp) begin
            if (gnt_port_q) begin
                p1_acc_cnt <= sat_inc(p1_acc_cnt);
                if (missed_q) begin
                    p1_miss_cnt <= sat_inc(p1_miss_cnt);
                end
            end else begin
                p0_acc_cnt <= sat_inc(p0_acc_cnt);
                if (missed_q) begin
                    p0_miss_cnt <= sat_inc(p0_miss_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for cache_port_arbiter.
// dut_a : round-robin, 32-bit counters, in front of a small cache model with
//         line-present bits and a fixed three-cycle swap on a miss.
// dut_b : fixed priority, 4-bit counters, in front of an always-hit cache.
// -----------------------------------------------------------------------------
module tb_cache_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ------------------------------------------------------------- dut_a
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_done, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] c_addr, c_wr_data, c_rd_data;
    logic        c_rd_req, c_wr_req, c_miss;
    logic        clear_stats = 0;
    logic [31:0] p0_acc_cnt, p0_miss_cnt, p1_acc_cnt, p1_miss_cnt;

    cache_port_arbiter #(.FIXED_PRIO(1'b0), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_rdata(p1_rdata),
        .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req),
        .c_wr_data(c_wr_data), .c_miss(c_miss), .c_rd_data(c_rd_data),
        .clear_stats(clear_stats),
        .p0_acc_cnt(p0_acc_cnt), .p0_miss_cnt(p0_miss_cnt),
        .p1_acc_cnt(p1_acc_cnt), .p1_miss_cnt(p1_miss_cnt)
    );

    // Cache model: word (addr>>2) initially holds 0xA5000000 | index.
    // Lines 0x40 and 0x80 are resident after reset; others miss for 3 cycles.
    logic [31:0] mem [0:4095];
    logic        present [0:1023];
    int          swap_cnt;

    assign c_miss = (c_rd_req || c_wr_req) && !present[c_addr[13:4]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hA500_0000 | i;
            for (int i = 0; i < 1024; i++) present[i] <= (i == 4) || (i == 8);
            swap_cnt  <= 0;
            c_rd_data <= 32'h0;
        end else if (c_rd_req || c_wr_req) begin
            if (c_miss) begin
                if (swap_cnt == 2) begin
                    present[c_addr[13:4]] <= 1'b1;
                    swap_cnt <= 0;
                end else begin
                    swap_cnt <= swap_cnt + 1;
                end
            end else if (c_rd_req) begin
                c_rd_data <= mem[c_addr[13:2]];
            end else begin
                mem[c_addr[13:2]] <= c_wr_data;
            end
        end
    end

    // ------------------------------------------------------------- dut_b
    logic        b_p0_req = 0, b_p1_req = 0;
    logic [31:0] b_p0_addr = 32'h100, b_p1_addr = 32'h200;
    logic        b_p0_done, b_p1_done;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic [31:0] b_c_addr, b_c_wr_data;
    logic [31:0] b_c_rd_data = 0;
    logic        b_c_rd_req, b_c_wr_req;
    logic        b_c_miss = 1'b0;
    logic        b_clear = 1'b0;
    logic [3:0]  b_p0_acc, b_p0_miss, b_p1_acc, b_p1_miss;

    cache_port_arbiter #(.FIXED_PRIO(1'b1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(b_p0_req), .p0_we(1'b0), .p0_addr(b_p0_addr), .p0_wdata(32'h0),
        .p0_done(b_p0_done), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_we(1'b0), .p1_addr(b_p1_addr), .p1_wdata(32'h0),
        .p1_done(b_p1_done), .p1_rdata(b_p1_rdata),
        .c_addr(b_c_addr), .c_rd_req(b_c_rd_req), .c_wr_req(b_c_wr_req),
        .c_wr_data(b_c_wr_data), .c_miss(b_c_miss), .c_rd_data(b_c_rd_data),
        .clear_stats(b_clear),
        .p0_acc_cnt(b_p0_acc), .p0_miss_cnt(b_p0_miss),
        .p1_acc_cnt(b_p1_acc), .p1_miss_cnt(b_p1_miss)
    );

    always @(posedge clk) begin
        if (b_c_rd_req) b_c_rd_data <= ~b_c_addr;
    end

    // Drive one access on dut_a from a negedge; returns at the negedge of the
    // done cycle with the request dropped. lat counts negedges until done.
    task automatic run_access(input int port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int lat, output int rd_cyc,
                              output int wr_cyc, output bit timed_out);
        lat = 0; rd_cyc = 0; wr_cyc = 0; timed_out = 1'b1;
        if (port == 0) begin
            p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (c_rd_req) rd_cyc++;
            if (c_wr_req) wr_cyc++;
            if ((port == 0 && p0_done) || (port == 1 && p1_done)) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (port == 0) p0_req = 0; else p1_req = 0;
    endtask

    int lat, rd_cyc, wr_cyc;
    bit to;

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({c_rd_req, c_wr_req, p0_done, p1_done} !== 4'b0 || c_addr !== 32'h0 ||
            p0_acc_cnt !== 32'h0 || p1_miss_cnt !== 32'h0 || p0_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: rd=%b wr=%b d0=%b d1=%b addr=%h acc0=%0d rdata0=%h expected all 0",
                     c_rd_req, c_wr_req, p0_done, p1_done, c_addr, p0_acc_cnt, p0_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        run_access(0, 1'b0, 32'h40, 32'h0, lat, rd_cyc, wr_cyc, to);
        n_vec++;
        if (to || lat !== 2) begin
            n_err++; $display("FAIL hit_latency: got %0d (timeout=%0b) expected 2", lat, to);
        end
        n_vec++;
        if (rd_cyc !== 1 || wr_cyc !== 0) begin
            n_err++; $display("FAIL hit_rd_req_cycles: rd=%0d wr=%0d expected rd=1 wr=0", rd_cyc, wr_cyc);
        end
        n_vec++;
        if (p0_rdata !== 32'hA500_0010) begin
            n_err++; $display("FAIL hit_rdata: got %h expected a5000010", p0_rdata);
        end
        @(negedge clk);
        n_vec++;
        if (p0_done !== 1'b0 || p0_acc_cnt !== 32'd1 || p0_miss_cnt !== 32'd0) begin
            n_err++; $display("FAIL hit_stats: done=%b acc=%0d miss=%0d expected 0/1/0",
                              p0_done, p0_acc_cnt, p0_miss_cnt);
        end
        n_vec++;
        if (p0_rdata !== 32'hA500_0010) begin
            n_err++; $display("FAIL hit_rdata_hold: got %h expected a5000010", p0_rdata);
        end
    endtask

    task automatic test_cold_miss();
        run_access(1, 1'b0, 32'h1000, 32'h0, lat, rd_cyc, wr_cyc, to);
        n_vec++;
        if (to || lat !== 5 || rd_cyc !== 4) begin
            n_err++; $display("FAIL miss_timing: lat=%0d rd=%0d timeout=%0b expected lat=5 rd=4", lat, rd_cyc, to);
        end
        n_vec++;
        if (p1_rdata !== 32'hA500_0400 || p0_done !== 1'b0) begin
            n_err++; $display("FAIL miss_rdata: got %h d0=%b expected a5000400 d0=0", p1_rdata, p0_done);
        end
        @(negedge clk);
        n_vec++;
        if (p1_done !== 1'b0 || p1_acc_cnt !== 32'd1 || p1_miss_cnt !== 32'd1 || p0_miss_cnt !== 32'd0) begin
            n_err++; $display("FAIL miss_stats: d1=%b acc1=%0d miss1=%0d miss0=%0d expected 0/1/1/0",
                              p1_done, p1_acc_cnt, p1_miss_cnt, p0_miss_cnt);
        end
    endtask

    task automatic test_round_robin();
        int order[4];
        int n = 0, c0 = 0, c1 = 0;
        int exp_order[4] = '{0, 1, 0, 1};
        p0_we = 0; p0_addr = 32'h40; p1_we = 0; p1_addr = 32'h80;
        p0_req = 1; p1_req = 1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (p0_done && p1_done) begin
                n_err++; $display("FAIL rr_both_done: d0=1 d1=1 expected at most one");
            end
            if (p0_done) begin
                order[n] = 0; n++; c0++;
                if (c0 == 2) p0_req = 0;
            end else if (p1_done) begin
                order[n] = 1; n++; c1++;
                if (c1 == 2) p1_req = 0;
            end
        end
        p0_req = 0; p1_req = 0;
        n_vec++;
        if (n !== 4) begin
            n_err++; $display("FAIL rr_count: got %0d dones expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (order[i] !== exp_order[i]) begin
                n_err++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, order[i], exp_order[i]);
            end
        end
        @(negedge clk);
        n_vec++;
        if (p0_acc_cnt !== 32'd3 || p1_acc_cnt !== 32'd3) begin
            n_err++; $display("FAIL rr_stats: acc0=%0d acc1=%0d expected 3/3", p0_acc_cnt, p1_acc_cnt);
        end
    endtask

    task automatic test_fixed_prio_saturate();
        int order[5];
        int n = 0, c0 = 0;
        int exp_order[5] = '{0, 0, 0, 0, 1};
        bit got;
        b_p0_req = 1; b_p1_req = 1;
        for (int i = 0; i < 60 && n < 5; i++) begin
            @(negedge clk);
            if (b_p0_done) begin
                order[n] = 0; n++; c0++;
                if (c0 == 4) b_p0_req = 0;
            end else if (b_p1_done) begin
                order[n] = 1; n++;
                b_p1_req = 0;
            end
        end
        b_p0_req = 0; b_p1_req = 0;
        n_vec++;
        if (n !== 5) begin
            n_err++; $display("FAIL fp_count: got %0d dones expected 5", n);
        end
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (order[i] !== exp_order[i]) begin
                n_err++; $display("FAIL fp_order[%0d]: got port %0d expected port %0d", i, order[i], exp_order[i]);
            end
        end
        // 11 more port-0 hits bring the total to 15, then one more at the ceiling
        for (int k = 0; k < 12; k++) begin
            b_p0_req = 1;
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (b_p0_done) got = 1;
            end
            b_p0_req = 0;
            n_vec++;
            if (!got) begin
                n_err++; $display("FAIL fp_hit_timeout: access %0d got no done expected done", k);
            end
            @(negedge clk);
            if (k == 10) begin
                n_vec++;
                if (b_p0_acc !== 4'd15) begin
                    n_err++; $display("FAIL sat_reach: got %0d expected 15", b_p0_acc);
                end
            end
        end
        n_vec++;
        if (b_p0_acc !== 4'd15 || b_p1_acc !== 4'd1 || b_p0_miss !== 4'd0) begin
            n_err++; $display("FAIL sat_hold: acc0=%0d acc1=%0d miss0=%0d expected 15/1/0",
                              b_p0_acc, b_p1_acc, b_p0_miss);
        end
    endtask

    task automatic test_write_then_read();
        run_access(0, 1'b1, 32'h80, 32'hDEAD_BEEF, lat, rd_cyc, wr_cyc, to);
        n_vec++;
        if (to || lat !== 2 || wr_cyc !== 1 || rd_cyc !== 0) begin
            n_err++; $display("FAIL wr_cycles: lat=%0d wr=%0d rd=%0d timeout=%0b expected 2/1/0", lat, wr_cyc, rd_cyc, to);
        end
        n_vec++;
        if (p0_rdata !== 32'hA500_0010) begin
            n_err++; $display("FAIL wr_rdata_unchanged: got %h expected a5000010", p0_rdata);
        end
        @(negedge clk);
        run_access(1, 1'b0, 32'h80, 32'h0, lat, rd_cyc, wr_cyc, to);
        n_vec++;
        if (to || wr_cyc !== 0 || rd_cyc !== 1) begin
            n_err++; $display("FAIL rd_after_wr_cycles: wr=%0d rd=%0d timeout=%0b expected 0/1", wr_cyc, rd_cyc, to);
        end
        n_vec++;
        if (p1_rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL rd_after_wr_data: got %h expected deadbeef", p1_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_miss();
        bit seen_done = 0;
        p0_we = 0; p0_addr = 32'h2000; p0_req = 1;
        @(negedge clk);
        n_vec++;
        if (c_rd_req !== 1'b1 || c_miss !== 1'b1) begin
            n_err++; $display("FAIL rmid_issue: rd=%b miss=%b expected 1/1", c_rd_req, c_miss);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({c_rd_req, c_wr_req, p0_done, p1_done} !== 4'b0 || c_addr !== 32'h0 ||
            p0_rdata !== 32'h0 || p1_rdata !== 32'h0 || p0_acc_cnt !== 32'h0 || p1_miss_cnt !== 32'h0) begin
            n_err++; $display("FAIL rmid_async: rd=%b addr=%h rdata0=%h rdata1=%h acc0=%0d expected all 0",
                              c_rd_req, c_addr, p0_rdata, p1_rdata, p0_acc_cnt);
        end
        p0_req = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (p0_done || p1_done) seen_done = 1;
        end
        n_vec++;
        if (seen_done) begin
            n_err++; $display("FAIL rmid_no_done: got a done pulse expected none");
        end
        run_access(0, 1'b0, 32'h40, 32'h0, lat, rd_cyc, wr_cyc, to);
        n_vec++;
        if (to || lat !== 2 || p0_rdata !== 32'hA500_0010) begin
            n_err++; $display("FAIL rmid_recover: lat=%0d rdata=%h timeout=%0b expected 2/a5000010", lat, p0_rdata, to);
        end
        @(negedge clk);
        n_vec++;
        if (p0_acc_cnt !== 32'd1 || p0_miss_cnt !== 32'd0) begin
            n_err++; $display("FAIL rmid_stats: acc=%0d miss=%0d expected 1/0", p0_acc_cnt, p0_miss_cnt);
        end
    endtask

    task automatic test_clear_stats();
        run_access(1, 1'b0, 32'h40, 32'h0, lat, rd_cyc, wr_cyc, to);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        n_vec++;
        if (to || p0_acc_cnt !== 32'd0 || p0_miss_cnt !== 32'd0 ||
            p1_acc_cnt !== 32'd0 || p1_miss_cnt !== 32'd0) begin
            n_err++; $display("FAIL clear_wins: acc0=%0d miss0=%0d acc1=%0d miss1=%0d timeout=%0b expected all 0",
                              p0_acc_cnt, p0_miss_cnt, p1_acc_cnt, p1_miss_cnt, to);
        end
        run_access(1, 1'b0, 32'h40, 32'h0, lat, rd_cyc, wr_cyc, to);
        @(negedge clk);
        n_vec++;
        if (to || p1_acc_cnt !== 32'd1 || p0_acc_cnt !== 32'd0) begin
            n_err++; $display("FAIL clear_resume: acc1=%0d acc0=%0d timeout=%0b expected 1/0", p1_acc_cnt, p0_acc_cnt, to);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_cold_miss();
        test_round_robin();
        test_fixed_prio_saturate();
        test_write_then_read();
        test_reset_mid_miss();
        test_clear_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
